// File: rtl/f_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues reads to a 1-cycle-latency IM,
// and buffers returned words in a prefetch FIFO that feeds decode via valid/ready.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_FETCH | issuing reads while the PC is legal and the FIFO has room
//   ST_HALT  | address-error entry queued; no issue until the next redirect
`timescale 1ns/1ps
module f_fetch_ctrl #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter int          ADDR_W     = 12,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              im_en,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [31:0]       im_rdata,
    input  logic              d_ready,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              f_valid,
    output logic [31:0]       f_instr,
    output logic [31:0]       f_pc,
    output logic              f_exc_adel
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;
    localparam logic [63:0] IM_BYTES = 64'd4 << ADDR_W;

    typedef enum logic {ST_FETCH, ST_HALT} fetch_state_t;

    fetch_state_t state, state_nxt;

    logic [31:0]   fetch_pc;
    logic [31:0]   tag_pc;
    logic          inflight;
    logic [31:0]   mem_instr [FIFO_DEPTH];
    logic [31:0]   mem_pc    [FIFO_DEPTH];
    logic          mem_exc   [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   hold_instr;
    logic [31:0]   hold_pc;
    logic          hold_exc;

    logic [32:0]   pc_off;
    logic [OW-1:0] occ;
    logic          addr_ok;
    logic          space;
    logic          halt;
    logic          pop;
    logic          ret_push;
    logic          exc_push;
    logic          push;
    logic [31:0]   push_instr;
    logic [31:0]   push_pc;
    logic          push_exc;

    assign pc_off  = {1'b0, fetch_pc} - {1'b0, PC_RESET};
    assign addr_ok = (fetch_pc[1:0] == 2'b00) && !pc_off[32]
                     && ({32'b0, pc_off[31:0]} < IM_BYTES);
    assign im_addr = pc_off[ADDR_W+1:2];

    assign f_valid = (count != '0);
    assign pop     = f_valid & d_ready;
    // Occupancy counts the word already in flight and credits this cycle's pop,
    // which is what lets d_ready feed straight through to im_en.
    assign occ     = {1'b0, count} + OW'(inflight) - OW'(pop);
    assign space   = (occ < OW'(FIFO_DEPTH));
    assign halt    = (state == ST_HALT);

    assign im_en    = !reset && !redirect && !halt && addr_ok && space;
    assign ret_push = inflight && !redirect;
    // The error entry waits for any in-flight word so the FIFO takes one push per edge
    // and the error lands behind the words fetched before it.
    assign exc_push = !addr_ok && !halt && !redirect && !inflight && space;
    assign push     = ret_push || exc_push;

    always_comb begin
        push_instr = im_rdata;
        push_pc    = tag_pc;
        push_exc   = 1'b0;
        if (exc_push) begin
            push_instr = 32'h0;
            push_pc    = fetch_pc;
            push_exc   = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = ST_FETCH;
        end else if (exc_push) begin
            state_nxt = ST_HALT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= PC_RESET;
            tag_pc   <= PC_RESET;
            inflight <= 1'b0;
        end else begin
            inflight <= im_en;
            if (im_en) begin
                tag_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (im_en) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hold_instr <= 32'h0;
            hold_pc    <= PC_RESET;
            hold_exc   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_instr[i] <= 32'h0;
                mem_pc[i]    <= PC_RESET;
                mem_exc[i]   <= 1'b0;
            end
        end else begin
            if (f_valid) begin
                hold_instr <= mem_instr[rd_ptr];
                hold_pc    <= mem_pc[rd_ptr];
                hold_exc   <= mem_exc[rd_ptr];
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem_instr[wr_ptr] <= push_instr;
                    mem_pc[wr_ptr]    <= push_pc;
                    mem_exc[wr_ptr]   <= push_exc;
                    wr_ptr            <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // An empty FIFO keeps showing the last head rather than stale storage.
    assign f_instr    = f_valid ? mem_instr[rd_ptr] : hold_instr;
    assign f_pc       = f_valid ? mem_pc[rd_ptr]    : hold_pc;
    assign f_exc_adel = f_valid ? mem_exc[rd_ptr]   : hold_exc;

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Bench for f_fetch_ctrl: cycle vectors for streaming/stall, hand sequences for
// redirect, address errors, range limits and async reset; delivered entries go through a scoreboard.
`timescale 1ns/1ps
module tb_f_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        im_en;
    logic [11:0] im_addr;
    logic [31:0] im_rdata = 32'h0;
    logic        d_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        f_exc_adel;

    f_fetch_ctrl dut (
        .clk(clk), .reset(reset), .im_en(im_en), .im_addr(im_addr), .im_rdata(im_rdata),
        .d_ready(d_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc), .f_exc_adel(f_exc_adel)
    );

    always #5 clk = ~clk;

    // IM model: IM[k] = 0x1000_0000 + k, registered read
    always @(posedge clk) if (im_en) im_rdata <= 32'h1000_0000 + {20'b0, im_addr};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
    } entry_t;

    typedef struct {
        logic        rst;
        logic        dr;
        logic        exp_en;
        logic [11:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    entry_t sb_q[$];
    entry_t mon_e;
    vec_t   tbl[15];
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic entry_t ent(input logic [31:0] pc, input logic exc);
        entry_t e;
        e.pc    = pc;
        e.exc   = exc;
        e.instr = exc ? 32'h0 : 32'h1000_0000 + ((pc - 32'h3000) >> 2);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && f_valid && d_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: actual f_pc=%h required no delivery at %0t", f_pc, $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_pc", f_pc, mon_e.pc);
                chk("sb_instr", f_instr, mon_e.instr);
                chk("sb_exc", {31'b0, f_exc_adel}, {31'b0, mon_e.exc});
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dr, input logic rd, input logic [31:0] rpc);
        d_ready     = dr;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        d_ready     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        sb_q.delete();
        @(posedge clk);
        #1;
        chk("rst_f_valid", {31'b0, f_valid}, 32'd0);
        chk("rst_im_en", {31'b0, im_en}, 32'd0);
        chk("rst_im_addr", {20'b0, im_addr}, 32'd0);
        chk("rst_f_pc", f_pc, 32'h3000);
        chk("rst_f_instr", f_instr, 32'h0);
        chk("rst_f_exc", {31'b0, f_exc_adel}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step(input logic dr, input logic rd, input logic [31:0] rpc,
                        input logic exp_en, input logic exp_valid,
                        input logic [31:0] exp_pc, input logic exp_exc);
        adv();
        if (exp_valid && dr) sb_q.push_back(ent(exp_pc, exp_exc));
        drive(dr, rd, rpc);
        chk("im_en", {31'b0, im_en}, {31'b0, exp_en});
        chk("f_valid", {31'b0, f_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            chk("f_pc", f_pc, exp_pc);
            chk("f_exc_adel", {31'b0, f_exc_adel}, {31'b0, exp_exc});
        end
    endtask

    task automatic run_table(input int lo, input int hi);
        entry_t e;
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].rst) do_reset();
            else adv();
            e = ent(tbl[i].exp_pc, 1'b0);
            if (tbl[i].exp_valid && tbl[i].dr) sb_q.push_back(e);
            drive(tbl[i].dr, 1'b0, 32'h0);
            chk($sformatf("v%0d_im_en", i), {31'b0, im_en}, {31'b0, tbl[i].exp_en});
            chk($sformatf("v%0d_im_addr", i), {20'b0, im_addr}, {20'b0, tbl[i].exp_addr});
            chk($sformatf("v%0d_f_valid", i), {31'b0, f_valid}, {31'b0, tbl[i].exp_valid});
            chk($sformatf("v%0d_f_pc", i), f_pc, tbl[i].exp_pc);
            chk($sformatf("v%0d_f_instr", i), f_instr, tbl[i].exp_valid ? e.instr : 32'h0);
        end
        adv();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // streaming from reset: rows 0-4
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 12'd0, 1'b0, 32'h3000};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 12'd1, 1'b0, 32'h3000};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 12'd2, 1'b1, 32'h3000};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 12'd3, 1'b1, 32'h3004};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 12'd4, 1'b1, 32'h3008};
        // 5-cycle decode stall after the first word: rows 5-14
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 12'd0, 1'b0, 32'h3000};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 12'd1, 1'b0, 32'h3000};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 12'd2, 1'b1, 32'h3000};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 12'd2, 1'b1, 32'h3000};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 12'd2, 1'b1, 32'h3000};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 12'd2, 1'b1, 32'h3000};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 12'd2, 1'b1, 32'h3000};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 12'd2, 1'b1, 32'h3000};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 12'd3, 1'b1, 32'h3004};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 12'd4, 1'b1, 32'h3008};

        run_table(0, 14);

        // redirect with a full FIFO and a pop in the redirect cycle
        do_reset();
        drive(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000, 1'b0);
        step(1'b1, 1'b1, 32'h3100, 1'b0, 1'b1, 32'h3000, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("redir_addr0", {20'b0, im_addr}, 32'h40);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("redir_addr1", {20'b0, im_addr}, 32'h41);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3100, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3104, 1'b0);

        // misaligned redirect while streaming (drops the in-flight 310C)
        step(1'b1, 1'b1, 32'h3102, 1'b0, 1'b1, 32'h3108, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3102, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("restart_addr", {20'b0, im_addr}, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 1'b0);

        // top of IM range, then below base
        step(1'b1, 1'b1, 32'h6FF8, 1'b0, 1'b1, 32'h3004, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("top_addr0", {20'b0, im_addr}, 32'hFFE);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("top_addr1", {20'b0, im_addr}, 32'hFFF);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6FF8, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6FFC, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7000, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h2FFC, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2FFC, 1'b1);

        // resume, then async reset mid-stream
        step(1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3004, 1'b0);
        adv();
        chk("pre_reset_drained", 32'(sb_q.size()), 32'd0);
        chk("pre_reset_valid", {31'b0, f_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_f_valid", {31'b0, f_valid}, 32'd0);
        chk("async_im_en", {31'b0, im_en}, 32'd0);
        chk("async_f_pc", f_pc, 32'h3000);
        run_table(0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
